// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the hazard/stall controller of the 5-stage MIPS core.
//   md_state_e   : mul/div sequencer states (RUN, MD_BUSY)
//   REG_ZERO     : architectural register 0, which never creates a hazard
//   CTRL_W       : width of the ID/EX control bundle; a bubble zeroes all bits
//   MD_CNT_W     : width of the mul/div latency down-counter (latency <= 255)
//   src_match()  : does destination d feed a source operand of the ID instruction
package hazard_stall_controller_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int CTRL_W = 7;
  typedef logic [CTRL_W-1:0] ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;

  localparam int MD_CNT_W = 8;

  // Register 0 is hard-wired, so writing it can never feed a later reader.
  function automatic logic src_match(input logic [4:0] d,
                                     input logic [4:0] src1,
                                     input logic [4:0] src2,
                                     input logic       uses_src2);
    return (d != REG_ZERO) && ((d == src1) || (uses_src2 && (d == src2)));
  endfunction

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating event counter used for performance debug.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count one event at this edge
//   cnt   : current count; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline control sequencer sitting beside ID. Every cycle it chooses
// advance, stall or flush for the front end and tracks the mul/div busy window.
//   Inputs : ID operand fields and kind (branch, mul/div, HI/LO reader),
//            branch outcome, EX and MEM destination/writeback/load info.
//   Outputs: pc_write_en, ifid_write_en (front-end enables), ifid_flush
//            (squash fetched instruction on taken branch), idex_bubble (NOP
//            into ID/EX), muldiv_busy (registered FSM state), stall_cnt and
//            flush_cnt (saturating performance counters).
// Handshake: none; outputs are level signals valid every cycle. Priority is
// reset > stall > flush > run.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MULDIV_LATENCY = 8,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_uses_src2,
  input  logic             id_is_br,
  input  logic             id_is_muldiv,
  input  logic             id_reads_hilo,
  input  logic             br_taken,
  input  logic [4:0]       ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_r_en,
  input  logic [4:0]       mem_dest,
  input  logic             mem_mem_r_en,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [MD_CNT_W-1:0] MD_INIT = MD_CNT_W'(MULDIV_LATENCY - 1);

  md_state_e           state, state_d;
  logic [MD_CNT_W-1:0] md_cnt, md_cnt_d;
  logic                br_wait, br_wait_d;

  logic hz_load, hz_br, hz_md, stall, flush_evt;

  // Hazard detection
  always_comb begin
    hz_load   = ex_mem_r_en && src_match(ex_dest, id_src1, id_src2, id_uses_src2);
    hz_br     = id_is_br &&
                ((ex_wb_en && src_match(ex_dest, id_src1, id_src2, id_uses_src2)) ||
                 (mem_mem_r_en && src_match(mem_dest, id_src1, id_src2, id_uses_src2)));
    hz_md     = muldiv_busy && (id_reads_hilo || id_is_muldiv);
    stall     = hz_load || hz_br || hz_md || br_wait;
    flush_evt = !stall && id_is_br && br_taken;
    // A branch waiting on a load needs a second stall cycle; remember it here
    // so the second cycle does not depend on the MEM-stage inputs arriving.
    br_wait_d = hz_load && id_is_br;
  end

  // Front-end control. Reset is folded in so the outputs react immediately
  // to an asynchronous reset assertion.
  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    if (!rst_n || stall) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_bubble   = 1'b1;
    end else if (flush_evt) begin
      ifid_flush = 1'b1;
    end
  end

  // Mul/div busy sequencer: next state
  always_comb begin
    state_d  = state;
    md_cnt_d = md_cnt;
    case (state)
      RUN: begin
        if (id_is_muldiv && !stall) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_INIT;
        end
      end
      MD_BUSY: begin
        if (md_cnt == '0) begin
          state_d = RUN;
        end else begin
          md_cnt_d = md_cnt - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      md_cnt  <= '0;
      br_wait <= 1'b0;
    end else begin
      state   <= state_d;
      md_cnt  <= md_cnt_d;
      br_wait <= br_wait_d;
    end
  end

  assign muldiv_busy = (state == MD_BUSY);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_evt),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  localparam int LAT     = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int EW      = 5 + 2 * CNT_W;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] src1;
    logic [4:0] src2;
    logic       uses2;
    logic       is_br;
    logic       is_md;
    logic       rd_hilo;
    logic       taken;
    logic [4:0] ex_dest;
    logic       ex_wb;
    logic       ex_ld;
    logic [4:0] mem_dest;
    logic       mem_ld;
  } stim_t;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_src1, id_src2, ex_dest, mem_dest;
  logic             id_uses_src2, id_is_br, id_is_muldiv, id_reads_hilo, br_taken;
  logic             ex_wb_en, ex_mem_r_en, mem_mem_r_en;
  logic             pc_write_en, ifid_write_en, ifid_flush, idex_bubble, muldiv_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MULDIV_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_src1       (id_src1),
    .id_src2       (id_src2),
    .id_uses_src2  (id_uses_src2),
    .id_is_br      (id_is_br),
    .id_is_muldiv  (id_is_muldiv),
    .id_reads_hilo (id_reads_hilo),
    .br_taken      (br_taken),
    .ex_dest       (ex_dest),
    .ex_wb_en      (ex_wb_en),
    .ex_mem_r_en   (ex_mem_r_en),
    .mem_dest      (mem_dest),
    .mem_mem_r_en  (mem_mem_r_en),
    .pc_write_en   (pc_write_en),
    .ifid_write_en (ifid_write_en),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .muldiv_busy   (muldiv_busy),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: remaining busy cycles, pending second branch stall,
  // and plain integer event counts.
  int m_busy_left = 0;
  bit m_br_wait   = 0;
  int m_stall     = 0;
  int m_flush     = 0;

  function automatic bit feeds(input logic [4:0] d, input stim_t s);
    return (d != 5'd0) && ((d == s.src1) || (s.uses2 && (d == s.src2)));
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input stim_t s);
    bit busy, ld, brd, md, stl, fl;
    logic [EW-1:0] e;
    @(posedge clk);
    #2;
    rst_n         = s.rst_n;
    id_src1       = s.src1;
    id_src2       = s.src2;
    id_uses_src2  = s.uses2;
    id_is_br      = s.is_br;
    id_is_muldiv  = s.is_md;
    id_reads_hilo = s.rd_hilo;
    br_taken      = s.taken;
    ex_dest       = s.ex_dest;
    ex_wb_en      = s.ex_wb;
    ex_mem_r_en   = s.ex_ld;
    mem_dest      = s.mem_dest;
    mem_mem_r_en  = s.mem_ld;
    if (!s.rst_n) begin
      m_busy_left = 0;
      m_br_wait   = 0;
      m_stall     = 0;
      m_flush     = 0;
      e = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CNT_W'(0), CNT_W'(0)};
    end else begin
      busy = (m_busy_left > 0);
      ld   = s.ex_ld && feeds(s.ex_dest, s);
      brd  = s.is_br && ((s.ex_wb && feeds(s.ex_dest, s)) || (s.mem_ld && feeds(s.mem_dest, s)));
      md   = busy && (s.rd_hilo || s.is_md);
      stl  = ld || brd || md || m_br_wait;
      fl   = !stl && s.is_br && s.taken;
      e = {!stl, !stl, fl, stl, busy, CNT_W'(m_stall), CNT_W'(m_flush)};
      if (stl && m_stall < CNT_MAX) m_stall++;
      if (fl && m_flush < CNT_MAX) m_flush++;
      m_br_wait = ld && s.is_br;
      if (busy) m_busy_left--;
      else if (s.is_md && !stl) m_busy_left = LAT;
    end
    exp_q.push_back(e);
  endtask

  // ---------------- monitor / checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_write_en",   32'(pc_write_en),   32'(e[EW-1]));
        chk("ifid_write_en", 32'(ifid_write_en), 32'(e[EW-2]));
        chk("ifid_flush",    32'(ifid_flush),    32'(e[EW-3]));
        chk("idex_bubble",   32'(idex_bubble),   32'(e[EW-4]));
        chk("muldiv_busy",   32'(muldiv_busy),   32'(e[EW-5]));
        chk("stall_cnt",     32'(stall_cnt),     32'(e[2*CNT_W-1:CNT_W]));
        chk("flush_cnt",     32'(flush_cnt),     32'(e[CNT_W-1:0]));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    {id_src1, id_src2, ex_dest, mem_dest} = '0;
    {id_uses_src2, id_is_br, id_is_muldiv, id_reads_hilo, br_taken} = '0;
    {ex_wb_en, ex_mem_r_en, mem_mem_r_en} = '0;
    rst_n = 1'b0;

    // reset held
    s = idle(); s.rst_n = 1'b0;
    repeat (2) apply(s);
    apply(idle());

    // load-use on rs, then pipeline moves on
    s = idle(); s.ex_ld = 1; s.ex_wb = 1; s.ex_dest = 5'd5; s.src1 = 5'd5;
    apply(s);
    apply(idle());
    // same shape but register 0
    s = idle(); s.ex_ld = 1; s.ex_dest = 5'd0; s.src1 = 5'd0;
    apply(s);
    apply(idle());

    // load then dependent taken branch, MEM info arriving on time
    s = idle(); s.ex_ld = 1; s.ex_wb = 1; s.ex_dest = 5'd8;
    s.is_br = 1; s.src2 = 5'd8; s.uses2 = 1; s.taken = 1;
    apply(s);
    s.ex_ld = 0; s.ex_wb = 0; s.mem_ld = 1; s.mem_dest = 5'd8;
    apply(s);
    s.mem_ld = 0;
    apply(s);
    apply(idle());
    // same, MEM load indication late
    s = idle(); s.ex_ld = 1; s.ex_wb = 1; s.ex_dest = 5'd8;
    s.is_br = 1; s.src2 = 5'd8; s.uses2 = 1; s.taken = 1;
    apply(s);
    s.ex_ld = 0; s.ex_wb = 0;
    apply(s);
    apply(s);
    apply(idle());

    // ALU result feeding a branch
    s = idle(); s.ex_wb = 1; s.ex_dest = 5'd3; s.is_br = 1; s.src1 = 5'd3; s.taken = 1;
    apply(s);
    s.ex_wb = 0;
    apply(s);
    apply(idle());

    // mult then mflo held in ID until it issues
    s = idle(); s.is_md = 1;
    apply(s);
    s = idle(); s.rd_hilo = 1;
    repeat (LAT + 1) apply(s);
    apply(idle());
    // independent add during busy, then a second mul/div during busy
    s = idle(); s.is_md = 1;
    apply(s);
    s = idle(); s.src1 = 5'd9; s.src2 = 5'd10; s.uses2 = 1;
    repeat (2) apply(s);
    s = idle(); s.is_md = 1;
    repeat (LAT + 1) apply(s);
    repeat (LAT + 1) apply(idle());

    // reset while busy
    s = idle(); s.is_md = 1;
    apply(s);
    s = idle(); s.rst_n = 1'b0;
    apply(s);
    apply(idle());
    s = idle(); s.rd_hilo = 1;
    apply(s);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      s = idle();
      s.rst_n    = ($urandom_range(0, 99) != 0);
      s.src1     = 5'($urandom_range(0, 3));
      s.src2     = 5'($urandom_range(0, 3));
      s.uses2    = 1'($urandom_range(0, 1));
      s.is_br    = ($urandom_range(0, 2) == 0);
      s.taken    = 1'($urandom_range(0, 1));
      s.is_md    = ($urandom_range(0, 5) == 0);
      s.rd_hilo  = ($urandom_range(0, 4) == 0);
      s.ex_dest  = 5'($urandom_range(0, 3));
      s.ex_wb    = 1'($urandom_range(0, 1));
      s.ex_ld    = ($urandom_range(0, 3) == 0);
      s.mem_dest = 5'($urandom_range(0, 3));
      s.mem_ld   = ($urandom_range(0, 3) == 0);
      apply(s);
    end

    // saturation: long run of stalls past the counter limit
    s = idle(); s.ex_ld = 1; s.ex_dest = 5'd7; s.src1 = 5'd7;
    repeat (CNT_MAX + 20) apply(s);
    apply(idle());

    // drain
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
